// File: rtl/ttfir_mac_if.sv
// Sample/coefficient/result bus of the ttfir time-multiplexed FIR filter.
// The master drives samples and coefficient words; the slave (the filter)
// returns the rounded, saturated result and its busy flag.
interface ttfir_mac_if #(
    parameter int BW_in   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_out  = 8
);
    logic signed [BW_in-1:0]   x_in;
    logic                      x_valid;
    logic                      coef_load;
    logic signed [BW_COEF-1:0] coef_in;
    logic signed [BW_out-1:0]  y_out;
    logic                      y_valid;
    logic                      busy;

    modport master (
        output x_in, x_valid, coef_load, coef_in,
        input  y_out, y_valid, busy
    );

    modport slave (
        input  x_in, x_valid, coef_load, coef_in,
        output y_out, y_valid, busy
    );
endinterface

// File: rtl/ttfir_mac.sv
// Time-multiplexed FIR filter: N_TAPS runtime-loadable coefficients share one
// multiplier-accumulator. Each accepted sample costs N_TAPS MAC cycles plus
// one output cycle; the result is rounded, arithmetic-shifted and saturated.
module ttfir_mac #(
    parameter int N_TAPS  = 4,
    parameter int BW_in   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_out  = 8,
    parameter int SHIFT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    ttfir_mac_if.slave  bus
);

    localparam int IDX_W  = $clog2(N_TAPS);
    localparam int PROD_W = BW_in + BW_COEF;
    localparam int ACC_W  = PROD_W + $clog2(N_TAPS);
    // Half-LSB of the shifted result; zero when no scaling is applied.
    localparam int RND_I  = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;

    localparam logic signed [ACC_W:0] RND   = (ACC_W + 1)'(RND_I);
    localparam logic signed [ACC_W:0] Y_MAX = (ACC_W + 1)'(2 ** (BW_out - 1) - 1);
    localparam logic signed [ACC_W:0] Y_MIN = (ACC_W + 1)'(-(2 ** (BW_out - 1)));

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t                    state_q, state_d;
    logic signed [BW_in-1:0]   d_q [N_TAPS];
    logic signed [BW_in-1:0]   d_d [N_TAPS];
    logic signed [BW_COEF-1:0] h_q [N_TAPS];
    logic signed [BW_COEF-1:0] h_d [N_TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [BW_out-1:0]  y_q, y_d;
    logic                      yv_q, yv_d;

    logic signed [PROD_W-1:0]  prod;
    logic signed [ACC_W:0]     rnd_sum;
    logic signed [ACC_W:0]     scaled;

    assign bus.busy    = (state_q != IDLE);
    assign bus.y_out   = y_q;
    assign bus.y_valid = yv_q;

    // Shared multiplier for the current tap, plus rounding and scaling of the accumulator.
    always_comb begin
        prod    = h_q[idx_q] * d_q[idx_q];
        rnd_sum = $signed({acc_q[ACC_W-1], acc_q}) + RND;
        scaled  = rnd_sum >>> SHIFT;
    end

    // Next-state logic: sample/coefficient intake in IDLE, tap walk in MAC, result in OUT.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        h_d     = h_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        yv_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // A sample takes priority; a simultaneous coefficient load is dropped.
                if (bus.x_valid) begin
                    for (int unsigned k = 1; k < N_TAPS; k++) begin
                        d_d[k] = d_q[k-1];
                    end
                    d_d[0]  = bus.x_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = MAC;
                end else if (bus.coef_load) begin
                    for (int unsigned k = 0; k < N_TAPS - 1; k++) begin
                        h_d[k] = h_q[k+1];
                    end
                    h_d[N_TAPS-1] = bus.coef_in;
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N_TAPS - 1)) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (scaled > Y_MAX) begin
                    y_d = Y_MAX[BW_out-1:0];
                end else if (scaled < Y_MIN) begin
                    y_d = Y_MIN[BW_out-1:0];
                end else begin
                    y_d = scaled[BW_out-1:0];
                end
                yv_d    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any sample in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int unsigned k = 0; k < N_TAPS; k++) begin
                d_q[k] <= '0;
                h_q[k] <= '0;
            end
            acc_q <= '0;
            idx_q <= '0;
            y_q   <= '0;
            yv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            h_q     <= h_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

endmodule

// File: tb/tb_ttfir_mac.sv
// Scoreboard bench for ttfir_mac: stimulus pushes hand-computed results with the
// cycle they are due; per-instance monitors pop and compare on every y_valid.
module tb_ttfir_mac;

    typedef struct {
        int y;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q1[$];
    exp_t q2[$];

    ttfir_mac_if #(.BW_in(6), .BW_COEF(6), .BW_out(8)) if1 ();
    ttfir_mac_if #(.BW_in(6), .BW_COEF(6), .BW_out(8)) if2 ();

    ttfir_mac #(.N_TAPS(4), .BW_in(6), .BW_COEF(6), .BW_out(8), .SHIFT(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    ttfir_mac #(.N_TAPS(4), .BW_in(6), .BW_COEF(6), .BW_out(8), .SHIFT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used to check result latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor for the unscaled instance.
    always @(negedge clk) begin
        if (rst && if1.y_valid) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_y_valid", 1, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_y_out", int'(if1.y_out), e.y);
                chk("dut1_latency", cyc, e.due);
            end
        end
    end

    // Monitor for the SHIFT=2 instance.
    always @(negedge clk) begin
        if (rst && if2.y_valid) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_y_valid", 1, 0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2_y_out", int'(if2.y_out), e.y);
                chk("dut2_latency", cyc, e.due);
            end
        end
    end

    task automatic drive(input int u, input logic xv, input logic signed [5:0] x,
                         input logic cl, input logic signed [5:0] c);
        if (u == 1) begin
            if1.x_valid = xv; if1.x_in = x; if1.coef_load = cl; if1.coef_in = c;
        end else begin
            if2.x_valid = xv; if2.x_in = x; if2.coef_load = cl; if2.coef_in = c;
        end
    endtask

    function automatic logic busy_of(input int u);
        return (u == 1) ? if1.busy : if2.busy;
    endfunction

    task automatic wait_idle(input int u);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy_of(u)) return;
        end
        chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic send(input int u, input logic signed [5:0] x, input int y, input bit push);
        exp_t e;
        wait_idle(u);
        drive(u, 1'b1, x, 1'b0, 6'sd0);
        if (push) begin
            e.y   = y;
            e.due = cyc + 6;
            if (u == 1) q1.push_back(e); else q2.push_back(e);
        end
        @(negedge clk);
        drive(u, 1'b0, 6'sd0, 1'b0, 6'sd0);
    endtask

    task automatic load(input int u, input logic signed [5:0] c);
        wait_idle(u);
        drive(u, 1'b0, 6'sd0, 1'b1, c);
        @(negedge clk);
        drive(u, 1'b0, 6'sd0, 1'b0, 6'sd0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        chk(name, q1.size() + q2.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int   k;
        int   exp5[4];
        exp_t e;
        exp5 = '{1, 9, 30, 70};

        drive(1, 1'b0, 6'sd0, 1'b0, 6'sd0);
        drive(2, 1'b0, 6'sd0, 1'b0, 6'sd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("reset_busy", int'(if1.busy), 0);
        chk("reset_y_valid", int'(if1.y_valid), 0);
        chk("reset_y_out", int'(if1.y_out), 0);

        // Zero coefficients after reset give a zero result.
        send(1, 6'sd17, 0, 1'b1);
        drain("drain_t1");

        // Impulse response with h = 1,2,3,4.
        pulse_reset();
        load(1, 6'sd1); load(1, 6'sd2); load(1, 6'sd3); load(1, 6'sd4);
        send(1, 6'sd1, 1, 1'b1);
        send(1, 6'sd0, 2, 1'b1);
        send(1, 6'sd0, 3, 1'b1);
        send(1, 6'sd0, 4, 1'b1);
        send(1, 6'sd0, 0, 1'b1);
        drain("drain_t2");

        // x_valid held high with x changing each cycle; coef_load held high too.
        k = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            drive(1, 1'b1, 6'(c + 1), 1'b1, -6'sd5);
            if (!if1.busy) begin
                if (k < 4) begin
                    e.y   = exp5[k];
                    e.due = cyc + 6;
                    q1.push_back(e);
                end
                k++;
            end
        end
        drive(1, 1'b0, 6'sd0, 1'b0, 6'sd0);
        chk("t5_accept_count", k, 4);
        drain("drain_t5");

        // Saturation: line holds 19,13,7,1 from the previous test.
        load(1, 6'sd31); load(1, 6'sd31); load(1, 6'sd31); load(1, 6'sd31);
        send(1, 6'sd31, 127, 1'b1);
        send(1, 6'sd31, 127, 1'b1);
        send(1, 6'sd31, 127, 1'b1);
        send(1, 6'sd31, 127, 1'b1);
        send(1, -6'sd32, 127, 1'b1);
        send(1, -6'sd32, -62, 1'b1);
        send(1, -6'sd32, -128, 1'b1);
        send(1, -6'sd32, -128, 1'b1);
        drain("drain_t3");

        // Rounding with SHIFT=2, h = 1,0,0,0.
        load(2, 6'sd1); load(2, 6'sd0); load(2, 6'sd0); load(2, 6'sd0);
        send(2, 6'sd6, 2, 1'b1);
        send(2, -6'sd6, -1, 1'b1);
        drain("drain_t4");

        // Reset during MAC aborts the sample; then filter from zeroed state.
        send(1, 6'sd5, 0, 1'b0);
        @(negedge clk);
        pulse_reset();
        chk("abort_busy", int'(if1.busy), 0);
        chk("abort_y_out", int'(if1.y_out), 0);
        chk("abort_y_valid", int'(if1.y_valid), 0);
        repeat (10) @(negedge clk);
        send(1, 6'sd9, 0, 1'b1);
        drain("drain_t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
